// File: rtl/reg_dump_streamer_pkg.sv
// Shared definitions for the register dump streamer: FSM encoding and frame constants.
// No logic here; imported by the top and the word serializer.
package reg_dump_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SEL   = 3'd2,
        ST_LATCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         WORD_BYTES    = 4;

    // Byte n of a word, counted from the MSB.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
        logic [7:0] b;
        case (n)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_dump_streamer_word_serializer.sv
// 32-bit word -> four MSB-first bytes on valid/ready; first byte valid the cycle after i_load.
// Holds the current byte while i_rdy is low; o_word_done flags the 4th transfer.
module reg_dump_streamer_word_serializer
    import reg_dump_streamer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_rdy,
    output logic [7:0]  o_dat,
    output logic        o_vld,
    output logic        o_word_done
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic        r_vld;
    logic        w_xfer;

    assign w_xfer = r_vld & i_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word     <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_vld      <= 1'b0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_byte_cnt <= 2'd0;
            r_vld      <= 1'b1;
        end else if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'(WORD_BYTES - 1)) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_dat       = word_byte(r_word, r_byte_cnt);
    assign o_vld       = r_vld;
    assign o_word_done = w_xfer && (r_byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/reg_dump_streamer.sv
// Sweeps reg_sel over all registers and streams A5 | 4 bytes/reg MSB-first | XOR csum; 6 cycles/reg.
// Every byte waits on i_tx_ready with data held; the FSM stalls in HDR, SEND or CSUM.
module reg_dump_streamer
    import reg_dump_streamer_pkg::*;
#(
    parameter int         NUM_REGS  = 32,
    parameter int         SEL_W     = 5,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [SEL_W-1:0] o_reg_sel,
    input  logic [31:0]      i_reg_data,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] r_reg_sel;
    logic [7:0]       r_csum;
    logic [7:0]       r_tx_dat;
    logic             r_tx_vld;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic [7:0]       w_ser_dat;
    logic             w_ser_vld;
    logic             w_ser_xfer;
    logic             w_word_done;
    logic             w_hc_xfer;

    // The word is captured at the end of LATCH, after reg_sel has been stable a full cycle.
    assign w_load     = (r_state == ST_LATCH);
    assign w_ser_xfer = w_ser_vld & i_tx_ready;
    assign w_hc_xfer  = r_tx_vld & i_tx_ready;

    reg_dump_streamer_word_serializer u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_word      (i_reg_data),
        .i_rdy       (i_tx_ready),
        .o_dat       (w_ser_dat),
        .o_vld       (w_ser_vld),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_reg_sel <= '0;
            r_csum    <= 8'd0;
            r_tx_dat  <= 8'd0;
            r_tx_vld  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_HDR;
                        r_busy   <= 1'b1;
                        r_tx_vld <= 1'b1;
                        r_tx_dat <= SYNC_BYTE;
                    end
                end
                ST_HDR: begin
                    if (w_hc_xfer) begin
                        r_tx_vld <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    r_reg_sel <= r_idx;
                    r_state   <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_ser_xfer) begin
                        r_csum <= r_csum ^ w_ser_dat;
                    end
                    if (w_word_done) begin
                        if (r_idx == LAST_IDX) begin
                            // The final data byte is folded in here, same edge it transfers.
                            r_tx_vld <= 1'b1;
                            r_tx_dat <= r_csum ^ w_ser_dat;
                            r_state  <= ST_CSUM;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_SEL;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_hc_xfer) begin
                        r_tx_vld <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_csum  <= 8'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_reg_sel  = r_reg_sel;
    assign o_tx_valid = r_tx_vld | w_ser_vld;
    assign o_tx_data  = w_ser_vld ? w_ser_dat : r_tx_dat;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: table of regfile patterns / ready modes plus hand-written corner sequences.
module tb_reg_dump_streamer;

    localparam int NR        = 32;
    localparam int FRAME_LEN = 2 + 4 * NR;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  sel;
    logic [31:0] rdata;
    logic [7:0]  txd;
    logic        txv;
    logic        ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    reg_dump_streamer #(.NUM_REGS(NR), .SEL_W(5), .SYNC_BYTE(8'hA5)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_reg_sel  (sel),
        .i_reg_data (rdata),
        .o_tx_data  (txd),
        .o_tx_valid (txv),
        .i_tx_ready (ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    int          cyc = 0;
    logic [31:0] rf [NR];
    logic [31:0] exp_w [NR];
    bit          dyn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Regfile model: static array, or a value that changes every cycle.
    always_comb begin
        rdata = rf[sel];
        if (dyn) rdata = {3'b000, sel, 8'h5C, cyc[15:0]};
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] cap_q[$];
    int         busy_rise = -1;
    int         done_cyc = -1;
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'd0;
    logic       prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid_held", 32'(txv), 32'd1);
                check("stall_data_held", 32'(txd), 32'(prev_dat));
            end
            prev_stall = txv && !ready && !rst;
            prev_dat   = txd;
            if (txv && ready && !rst) cap_q.push_back(txd);
            if (busy && !prev_busy) busy_rise = cyc;
            prev_busy = busy;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    // ---------------- ready driver ----------------
    int ready_mode = 0;   // 0 high, 1 toggle, 2 random, 3 manual

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                2:       ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];

    function automatic void build_exp();
        logic [7:0] cs;
        logic [7:0] by;
        cs = 8'd0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NR; i++) begin
            for (int b = 0; b < 4; b++) begin
                by = 8'(exp_w[i] >> (24 - 8 * b));
                cs ^= by;
                exp_q.push_back(by);
            end
        end
        exp_q.push_back(cs);
    endfunction

    task automatic fill(input int pat, input bit ovr);
        for (int i = 0; i < NR; i++) begin
            case (pat)
                0:       rf[i] = 32'h01010101 * 32'(i);
                1:       rf[i] = 32'(i);
                default: rf[i] = $urandom;
            endcase
        end
        if (ovr) rf[NR-1] = 32'h00000020;
        for (int i = 0; i < NR; i++) exp_w[i] = rf[i];
    endtask

    task automatic compare_frame(input string name);
        build_exp();
        check($sformatf("%s_len", name), 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 of the done cycle; settle moves past that cycle's monitor sample.
    task automatic wait_done(input string name, input bit settle);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done pulse, required one within 5000 cycles", name);
        end
        if (settle) begin
            @(negedge clk); #1;
        end
    endtask

    typedef struct {
        int         pat;
        int         rmode;
        bit         ovr;
        bit         const_cs;
        logic [7:0] cs;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{pat: 0, rmode: 0, ovr: 1'b0, const_cs: 1'b1, cs: 8'h00};
        vt[1] = '{pat: 1, rmode: 0, ovr: 1'b0, const_cs: 1'b1, cs: 8'h00};
        vt[2] = '{pat: 1, rmode: 0, ovr: 1'b1, const_cs: 1'b1, cs: 8'h3F};
        vt[3] = '{pat: 2, rmode: 1, ovr: 1'b0, const_cs: 1'b0, cs: 8'h00};
        vt[4] = '{pat: 2, rmode: 2, ovr: 1'b0, const_cs: 1'b0, cs: 8'h00};
        vt[5] = '{pat: 0, rmode: 2, ovr: 1'b0, const_cs: 1'b1, cs: 8'h00};

        start = 1'b0;
        rst   = 1'b1;
        fill(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_sel", 32'(sel), 32'd0);
        check("rst_tx_valid", 32'(txv), 32'd0);
        check("rst_tx_data", 32'(txd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx_valid", 32'(txv), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            fill(vt[v].pat, vt[v].ovr);
            ready_mode = vt[v].rmode;
            cap_q.delete();
            done_cnt = 0;
            pulse_start();
            wait_done($sformatf("vec%0d", v), 1'b1);
            compare_frame($sformatf("vec%0d", v));
            check($sformatf("vec%0d_done_cnt", v), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d_sel_hold", v), 32'(sel), 32'(NR - 1));
            if (vt[v].const_cs && cap_q.size() > 0)
                check($sformatf("vec%0d_csum", v), 32'(cap_q[cap_q.size()-1]), 32'(vt[v].cs));
            if (vt[v].rmode == 0)
                check($sformatf("vec%0d_latency", v), 32'(done_cyc - busy_rise + 1), 32'd195);
        end
        ready_mode = 0;

        // Stall 10 cycles in HDR, then mid-SEND
        fill(0, 1'b0);
        build_exp();
        ready_mode = 3;
        ready = 1'b0;
        cap_q.delete();
        pulse_start();
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("hdr_stall_valid", 32'(txv), 32'd1);
        check("hdr_stall_data", 32'(txd), 32'h0000_00A5);
        ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (cap_q.size() >= 15) break;
        end
        ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("send_stall_valid", 32'(txv), 32'd1);
        check("send_stall_data", 32'(txd), 32'(exp_q[15]));
        ready = 1'b1;
        wait_done("stall", 1'b1);
        compare_frame("stall");
        ready_mode = 0;

        // start while busy ignored; start in DONE ignored; start on first IDLE accepted
        fill(0, 1'b0);
        cap_q.delete();
        done_cnt = 0;
        pulse_start();
        repeat (48) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_restart_busy", 32'(busy), 32'd1);
        wait_done("b2b_first", 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("b2b_done_cnt1", 32'(done_cnt), 32'd1);
        compare_frame("b2b_first");
        cap_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_done_busy", 32'(busy), 32'd1);
        wait_done("b2b_second", 1'b1);
        compare_frame("b2b_second");
        check("b2b_done_cnt2", 32'(done_cnt), 32'd2);

        // Reset during SEND of register 12
        fill(2, 1'b0);
        cap_q.delete();
        pulse_start();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (sel == 5'd12 && txv) break;
        end
        check("pre_rst_in_reg12", 32'(sel), 32'd12);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx_valid", 32'(txv), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_reg_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        cap_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_done("post_rst", 1'b1);
        compare_frame("post_rst");

        // reg_data changing every cycle: word is whatever was present in LATCH
        dyn = 1'b1;
        cap_q.delete();
        pulse_start();
        wait_done("dyn", 1'b1);
        for (int i = 0; i < NR; i++)
            exp_w[i] = {3'b000, 5'(i), 8'h5C, 16'(busy_rise + 2 + 6 * i)};
        compare_frame("dyn");
        dyn = 1'b0;

        check("frame_len_const", 32'(exp_q.size()), 32'(FRAME_LEN));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
